// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: circular byte FIFO in front of a UART transmitter.
// Bytes pushed by the system side are stored in the FIFO. They are launched one
// at a time with a single-cycle tx_start. The next byte is launched only after
// the transmitter returns tx_done.
module uart_tx_feeder #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                full_w, empty_w, push, pop;

  // The transmitter's busy flag is status only; the sequencing relies on tx_done alone.
  logic unused_tx_active;
  assign unused_tx_active = tx_active;

  // count never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign full_w  = count_q[ADDR_W];
  assign empty_w = (count_q == '0);

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign push = wr_en && !full_w;
  assign pop  = (state_q == S_IDLE) && !empty_w && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: launch one byte, then wait for its completion pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (tx_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the next state.
  always_comb begin
    tx_start_d = (state_d == S_LAUNCH);
    busy_d     = (state_d != S_IDLE);
    tx_byte_d  = pop ? mem_q[rd_ptr_q] : tx_byte_q;
    overflow_d = wr_en && full_w;
  end

  // FIFO bookkeeping. A flush clears the pointers and count and overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // Byte storage; contents are not reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a byte scoreboard and a simple transmitter model.
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic       busy;

  // Transmitter model / manual done pulse.
  logic       m_done = 1'b0;
  logic       man_done;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_lat = 8'h00;
  logic       auto_tx;
  int         tx_len;

  // Scoreboard and bookkeeping.
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cyc = 0;
  logic       done_valid = 1'b0;
  logic       gap_chk;
  int         n_gap = 0;
  int         n_starts = 0;
  logic       prev_start = 1'b0;
  int         starts_before;

  assign tx_done   = m_done | man_done;
  assign tx_active = m_busy;

  uart_tx_feeder #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_active(tx_active),
    .tx_done(tx_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Wait until every queued byte has been launched and the last one completed.
  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < budget, 1'b1);
  endtask

  // Cycle counter; records the cycle in which the DUT samples tx_done.
  always @(posedge clk) begin
    if (tx_done === 1'b1) begin
      done_cyc   = cyc;
      done_valid = 1'b1;
    end
    cyc = cyc + 1;
  end

  // Scoreboard monitor: every launch must match the next expected byte.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      n_starts++;
      chk("start_single", prev_start, 1'b0);
      chk("start_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("tx_byte_order", tx_byte, exp_q.pop_front());
      if (gap_chk && done_valid) begin
        chk("done_to_start_gap", cyc - done_cyc, 2);
        n_gap++;
      end
    end
    prev_start = (tx_start === 1'b1);
  end

  // Transmitter model: latches the byte at start, signals done after tx_len cycles.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (m_busy) begin
      m_cnt++;
      if (m_cnt >= tx_len) begin
        chk("tx_byte_hold", tx_byte, m_lat);
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (auto_tx && tx_start === 1'b1) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_lat  = tx_byte;
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    man_done = 1'b0; auto_tx = 1'b0; gap_chk = 1'b0; tx_len = 4;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // 1: single byte, launch latency and hold
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk); wr_en = 1'b0;
    chk("t1_count1", count, 1);
    chk("t1_empty0", empty, 0);
    chk("t1_nostart", tx_start, 0);
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    chk("t1_busy", busy, 1);
    chk("t1_count0", count, 0);
    @(negedge clk);
    chk("t1_start_low", tx_start, 0);
    repeat (5) @(negedge clk);
    chk("t1_hold", tx_byte, 8'hA5);
    chk("t1_busy_wait", busy, 1);
    man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    chk("t1_busy_clear", busy, 0);
    chk("t1_hold_after", tx_byte, 8'hA5);
    chk("t1_count_end", count, 0);
    repeat (4) @(negedge clk);

    // 2: five bytes with full-length serial timing
    auto_tx = 1'b1; tx_len = 8680; gap_chk = 1'b1; done_valid = 1'b0; n_gap = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
    end
    @(negedge clk); wr_en = 1'b0;
    drain(50000);
    chk("t2_gap_checks", n_gap, 4);
    gap_chk = 1'b0;
    @(negedge clk); auto_tx = 1'b0;

    // 3: fill, overflow, drain with pointer wrap
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
    end
    @(negedge clk);
    chk("t3_count16", count, 16);
    chk("t3_full", full, 1);
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk); wr_en = 1'b0;
    chk("t3_overflow", overflow, 1);
    chk("t3_count_kept", count, 16);
    @(negedge clk);
    chk("t3_overflow_pulse", overflow, 0);
    auto_tx = 1'b1; tx_len = 4; man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    drain(2000);
    chk("t3_count_end", count, 0);
    chk("t3_empty_end", empty, 1);
    @(negedge clk); auto_tx = 1'b0;

    // 4: push+pop on a full FIFO, then on a half-full FIFO
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'h30 + i); exp_q.push_back(8'(8'h30 + i));
    end
    @(negedge clk); wr_en = 1'b0;
    chk("t4_full", full, 1);
    man_done = 1'b1;
    @(negedge clk); man_done = 1'b0; wr_en = 1'b1; wr_data = 8'hBB;
    @(negedge clk); wr_en = 1'b0;
    chk("t4_overflow", overflow, 1);
    chk("t4_count15", count, 15);
    chk("t4_not_full", full, 0);
    chk("t4_start", tx_start, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); man_done = 1'b1;
      @(negedge clk); man_done = 1'b0;
      @(negedge clk);
    end
    chk("t4_count8", count, 8);
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0; wr_en = 1'b1; wr_data = 8'hC4; exp_q.push_back(8'hC4);
    @(negedge clk); wr_en = 1'b0;
    chk("t4_count_same", count, 8);
    chk("t4_no_overflow", overflow, 0);
    chk("t4_start2", tx_start, 1);
    @(negedge clk); auto_tx = 1'b1; tx_len = 3; man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    drain(2000);
    chk("t4_count_end", count, 0);
    @(negedge clk); auto_tx = 1'b0;

    // 5: flush while a byte is in flight with three queued
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      if (i == 0) exp_q.push_back(8'h50);
    end
    @(negedge clk); wr_en = 1'b0;
    chk("t5_count3", count, 3);
    chk("t5_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("t5_flushed", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_still_busy", busy, 1);
    starts_before = n_starts;
    man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    chk("t5_done", busy, 0);
    repeat (8) @(negedge clk);
    chk("t5_no_start", n_starts, starts_before);
    chk("t5_idle", busy, 0);

    // 6: reset during WAIT, late done ignored
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h60; exp_q.push_back(8'h60);
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_busy0", busy, 0);
    chk("t6_start0", tx_start, 0);
    chk("t6_byte0", tx_byte, 8'h00);
    chk("t6_count0", count, 0);
    chk("t6_empty1", empty, 1);
    chk("t6_full0", full, 0);
    chk("t6_ovf0", overflow, 0);
    starts_before = n_starts;
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_start", n_starts, starts_before);
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
